// File: rtl/sump_cmd_decoder.sv
// SUMP host command parser: assembles 1-byte and 5-byte commands from the receive byte stream
// and emits registered opcode/payload with execute and decoded one-cycle strobes.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMER_WIDTH    = 20
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] cmd_data,
  output logic        execute,
  output logic        sump_reset,
  output logic        arm,
  output logic        query_id,
  output logic        query_metadata,
  output logic        flow_stop,
  output logic        timeout_err
);

  localparam logic [TIMER_WIDTH-1:0] TimerMax = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StRead} state_e;

  state_e                 state_q;
  logic [1:0]             count_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [7:0]             hold_q;
  logic [23:0]            payload_q;

  logic [7:0]  opcode_q;
  logic [31:0] cmd_data_q;
  logic        execute_q, sump_reset_q, arm_q, query_id_q, query_meta_q, flow_stop_q, timeout_q;

  // Command completing on this edge, with the opcode/payload it will present.
  logic        done;
  logic [7:0]  done_op;
  logic [31:0] done_data;

  always_comb begin
    done      = 1'b0;
    done_op   = rx_data;
    done_data = 32'h0;
    if (rx_valid) begin
      if (state_q == StIdle && !rx_data[7]) begin
        done = 1'b1;
      end else if (state_q == StRead && count_q == 2'd3) begin
        done      = 1'b1;
        done_op   = hold_q;
        done_data = {rx_data, payload_q};
      end
    end
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state_q      <= StIdle;
      count_q      <= 2'd0;
      timer_q      <= '0;
      hold_q       <= 8'h0;
      payload_q    <= 24'h0;
      opcode_q     <= 8'h0;
      cmd_data_q   <= 32'h0;
      execute_q    <= 1'b0;
      sump_reset_q <= 1'b0;
      arm_q        <= 1'b0;
      query_id_q   <= 1'b0;
      query_meta_q <= 1'b0;
      flow_stop_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      execute_q    <= done;
      sump_reset_q <= done && (done_op == 8'h00);
      arm_q        <= done && (done_op == 8'h01);
      query_id_q   <= done && (done_op == 8'h02);
      query_meta_q <= done && (done_op == 8'h04);
      timeout_q    <= 1'b0;
      if (done) begin
        opcode_q   <= done_op;
        cmd_data_q <= done_data;
        if (done_op == 8'h13) begin
          flow_stop_q <= 1'b1;
        end else if (done_op == 8'h11) begin
          flow_stop_q <= 1'b0;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            hold_q <= rx_data;
            if (rx_data[7]) begin
              state_q <= StRead;
              count_q <= 2'd0;
              timer_q <= '0;
            end
          end
        end
        StRead: begin
          if (rx_valid) begin
            case (count_q)
              2'd0:    payload_q[7:0]   <= rx_data;
              2'd1:    payload_q[15:8]  <= rx_data;
              2'd2:    payload_q[23:16] <= rx_data;
              default: state_q          <= StIdle;
            endcase
            count_q <= count_q + 2'd1;
            timer_q <= '0;
          end else if (timer_q == TimerMax) begin
            // Host stalled mid-command: drop the partial payload and resync.
            state_q   <= StIdle;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign opcode         = opcode_q;
  assign cmd_data       = cmd_data_q;
  assign execute        = execute_q;
  assign sump_reset     = sump_reset_q;
  assign arm            = arm_q;
  assign query_id       = query_id_q;
  assign query_metadata = query_meta_q;
  assign flow_stop      = flow_stop_q;
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios plus random byte streams, each cycle compared
// against a byte-queue reference model of the command protocol.
module tb_sump_cmd_decoder;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        extReset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  opcode;
  logic [31:0] cmd_data;
  logic        execute, sump_reset, arm, query_id, query_metadata, flow_stop, timeout_err;

  sump_cmd_decoder #(
    .TIMEOUT_CYCLES(TO),
    .TIMER_WIDTH   (5)
  ) dut (
    .clock         (clock),
    .extReset_n    (extReset_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .opcode        (opcode),
    .cmd_data      (cmd_data),
    .execute       (execute),
    .sump_reset    (sump_reset),
    .arm           (arm),
    .query_id      (query_id),
    .query_metadata(query_metadata),
    .flow_stop     (flow_stop),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending command bytes and idle cycles since the last byte.
  bit         m_long;
  logic [7:0] m_bytes[$];
  int         m_idle;
  logic [7:0]  e_op;
  logic [31:0] e_data;
  logic e_exec, e_rst, e_arm, e_qid, e_qmeta, e_flow, e_tout;

  function automatic logic [46:0] obs();
    return {opcode, cmd_data, execute, sump_reset, arm, query_id, query_metadata, flow_stop,
            timeout_err};
  endfunction

  function automatic logic [46:0] expv();
    return {e_op, e_data, e_exec, e_rst, e_arm, e_qid, e_qmeta, e_flow, e_tout};
  endfunction

  task automatic model_reset();
    m_long = 0; m_bytes.delete(); m_idle = 0;
    e_op = 0; e_data = 0; e_flow = 0;
    e_exec = 0; e_rst = 0; e_arm = 0; e_qid = 0; e_qmeta = 0; e_tout = 0;
  endtask

  task automatic model_complete(input logic [7:0] op, input logic [31:0] data);
    e_op = op; e_data = data; e_exec = 1;
    e_rst = (op == 8'h00); e_arm = (op == 8'h01); e_qid = (op == 8'h02); e_qmeta = (op == 8'h04);
    if (op == 8'h13) e_flow = 1;
    else if (op == 8'h11) e_flow = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    e_exec = 0; e_rst = 0; e_arm = 0; e_qid = 0; e_qmeta = 0; e_tout = 0;
    if (!m_long) begin
      if (v) begin
        if (!d[7]) model_complete(d, 32'h0);
        else begin m_long = 1; m_bytes = {d}; m_idle = 0; end
      end
    end else if (v) begin
      m_bytes.push_back(d);
      m_idle = 0;
      if (m_bytes.size() == 5) begin
        model_complete(m_bytes[0], {m_bytes[4], m_bytes[3], m_bytes[2], m_bytes[1]});
        m_long = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin e_tout = 1; m_long = 0; end
    end
  endtask

  // One clock: present the byte, sample outputs 1 ns after the edge, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    #1;
    model_step(v, d);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    extReset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (obs() !== 47'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs(), 47'h0);
    end
    #2 extReset_n = 1'b1;
  endtask

  task automatic test_short();
    cycle(1'b1, 8'h04);
    n_cmp++;
    if (obs() !== expv() || query_metadata !== 1'b1 || cmd_data !== 32'h0) begin
      n_bad++; $display("FAIL short_query_metadata: got %h want %h", obs(), expv());
    end
    cycle(1'b0, 8'h00);
    n_cmp++;
    if (obs() !== expv() || execute !== 1'b0) begin
      n_bad++; $display("FAIL short_pulse_width: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_long();
    logic [7:0] seq[5] = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
    int execs = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 5, (i < 5) ? seq[i] : 8'h00);
      execs += int'(execute);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL long_cycle%0d: got %h want %h", i, obs(), expv());
      end
      if (i == 4) begin
        n_cmp++;
        if (execute !== 1'b1 || opcode !== 8'hC0 || cmd_data !== 32'h12345678) begin
          n_bad++;
          $display("FAIL long_payload: got exec=%b op=%h data=%h want 1 c0 12345678",
                   execute, opcode, cmd_data);
        end
      end
    end
    n_cmp++;
    if (execs != 1) begin
      n_bad++; $display("FAIL long_exec_count: got %0d want 1", execs);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] seq[3] = '{8'h81, 8'hAA, 8'hBB};
    int touts = 0, execs = 0;
    foreach (seq[i]) cycle(1'b1, seq[i]);
    for (int i = 0; i < TO + 2; i++) begin
      cycle(1'b0, 8'h00);
      touts += int'(timeout_err);
      execs += int'(execute);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL timeout_idle%0d: got %h want %h", i, obs(), expv());
      end
      if (i == TO - 1) begin
        n_cmp++;
        if (timeout_err !== 1'b1) begin
          n_bad++; $display("FAIL timeout_at_limit: got %b want 1", timeout_err);
        end
      end
    end
    n_cmp++;
    if (touts != 1 || execs != 0) begin
      n_bad++; $display("FAIL timeout_counts: got touts=%0d execs=%0d want 1 0", touts, execs);
    end
    cycle(1'b1, 8'h02);
    n_cmp++;
    if (obs() !== expv() || query_id !== 1'b1 || opcode !== 8'h02) begin
      n_bad++; $display("FAIL timeout_resync: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_expire_edge();
    cycle(1'b1, 8'h85);
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    for (int i = 0; i < TO - 1; i++) begin
      cycle(1'b0, 8'h00);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL edge_idle%0d: got %h want %h", i, obs(), expv());
      end
    end
    cycle(1'b1, 8'h04);
    n_cmp++;
    if (obs() !== expv() || execute !== 1'b1 || timeout_err !== 1'b0 ||
        cmd_data !== 32'h04030201) begin
      n_bad++; $display("FAIL edge_byte_wins: got %h want %h", obs(), expv());
    end
    cycle(1'b1, 8'h01);
    n_cmp++;
    if (obs() !== expv() || arm !== 1'b1) begin
      n_bad++; $display("FAIL back_to_back_arm: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_flow();
    logic [7:0] seq[3] = '{8'h13, 8'h00, 8'h11};
    logic       want_flow[3] = '{1'b1, 1'b1, 1'b0};
    foreach (seq[i]) begin
      cycle(1'b1, seq[i]);
      n_cmp++;
      if (obs() !== expv() || flow_stop !== want_flow[i]) begin
        n_bad++; $display("FAIL flow_%h: got %h want %h", seq[i], obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    int resets = 0;
    cycle(1'b1, 8'h90);
    cycle(1'b1, 8'h11);
    extReset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs() !== 47'h0) begin
      n_bad++; $display("FAIL reset_mid_async: got %h want %h", obs(), 47'h0);
    end
    #1 extReset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(i < 5, 8'h00);
      resets += int'(sump_reset);
      n_cmp++;
      if (obs() !== expv() || cmd_data !== 32'h0) begin
        n_bad++; $display("FAIL resync_cycle%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (resets != 5) begin
      n_bad++; $display("FAIL resync_count: got %0d want 5", resets);
    end
  endtask

  task automatic test_random();
    logic [7:0] picks[7] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13, 8'h80};
    int gap;
    logic [7:0] b;
    for (int n = 0; n < 400; n++) begin
      gap = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 3, TO + 3))
                                        : int'($urandom_range(0, 2));
      for (int g = 0; g <= gap; g++) begin
        b = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 6)] : 8'($urandom);
        cycle(g == gap, b);
        n_cmp++;
        if (obs() !== expv()) begin
          n_bad++; $display("FAIL random_%0d_%0d: got %h want %h", n, g, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_timeout();
    test_expire_edge();
    test_flow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
Receive-side command parser for the SUMP host protocol. It consumes the byte stream from the UART/SPI receiver and assembles short (1-byte) and long (5-byte) commands. It presents each completed command as an opcode plus a 32-bit payload with a one-cycle execute strobe. It also produces decoded strobes, including query_metadata for the meta data sender on the transmit side, and an inter-byte timeout that resynchronises a host that stalls mid-command.

Parameters:
TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of a long command before it is discarded (1 ms at 100 MHz); legal range 2..2^20-1
TIMER_WIDTH, 20, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clock  in  1  system clock, all logic on rising edge
extReset_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte, valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
opcode  out  8  opcode of the last completed command
cmd_data  out  32  payload of the last completed command, first payload byte in [7:0]; 0 for short commands
execute  out  1  one-cycle pulse, command in opcode/cmd_data is complete
sump_reset  out  1  pulse with execute when opcode==8'h00
arm  out  1  pulse with execute when opcode==8'h01
query_id  out  1  pulse with execute when opcode==8'h02
query_metadata  out  1  pulse with execute when opcode==8'h04
flow_stop  out  1  level; set by opcode 8'h13 (XOFF), cleared by 8'h11 (XON)
timeout_err  out  1  one-cycle pulse when a partial long command is discarded

Behaviour:
- Reset (extReset_n=0, async): state=IDLE, byte count=0, timer=0, opcode=0, cmd_data=0, flow_stop=0, all pulse outputs 0.
- All outputs are registered; no combinational path from rx_* to outputs.
- FSM states:
  - IDLE: on rx_valid, latch rx_data into the opcode holding register.
    - If rx_data[7]=0: short command; the same edge schedules completion.
    - If rx_data[7]=1: clear byte count and timer, go to READ.
  - READ: on rx_valid, store rx_data into payload byte [count] (little-endian: byte0 -> [7:0], byte3 -> [31:24]), count+1, timer cleared.
    - When the 4th payload byte is stored, go to IDLE and schedule completion.
    - On cycles without rx_valid, timer+1.
    - When timer reaches TIMEOUT_CYCLES-1 with no rx_valid: go to IDLE, pulse timeout_err next cycle, discard the partial payload; opcode/cmd_data outputs are unchanged.
- Completion timing: opcode and cmd_data are updated, and execute plus the matching decoded strobe assert, on the clock after the edge that sampled the final byte (latency 1). Pulses last exactly one cycle. A short command forces cmd_data=0.
- Because the FSM is back in IDLE when execute asserts, a byte arriving in the execute cycle starts a new command. No byte is ever dropped; back-to-back rx_valid every cycle is supported.
- rx_valid in the same cycle the timer would expire: the byte wins, timer clears, no timeout_err.
- Unknown opcodes still produce execute with opcode/cmd_data; no decoded strobe fires.
- flow_stop is updated in the execute cycle of 8'h13/8'h11; sump_reset does not clear it, only extReset_n does.
- Five consecutive 8'h00 bytes (SUMP resync) yield five sump_reset pulses. Any pending long command is resolved only by its bytes or by timeout.
- Reset asserted mid-command: partial payload discarded, FSM in IDLE, no pulses generated on release.
- rx_data is ignored whenever rx_valid=0.

Test Plan:
1. After reset, send 8'h04 -> exactly one execute and query_metadata pulse 1 cycle later, opcode=8'h04, cmd_data=0; other strobes stay 0.
2. Send 8'hC0,8'h78,8'h56,8'h34,8'h12 on 5 consecutive cycles -> single execute 1 cycle after last byte, opcode=8'hC0, cmd_data=32'h12345678; no strobes.
3. Send 8'h81,8'hAA,8'hBB, then idle TIMEOUT_CYCLES (bench param 16) -> timeout_err one pulse, no execute. Then 8'h02 -> query_id pulse, opcode=8'h02.
4. Long command whose 4th payload byte arrives exactly on the would-expire cycle -> execute, no timeout_err. Whole command followed immediately by 8'h01 on the execute cycle -> arm pulse next cycle.
5. Send 8'h13 -> flow_stop=1. Send 8'h00 -> sump_reset pulse, flow_stop stays 1. Send 8'h11 -> flow_stop=0.
6. Assert extReset_n=0 after the 2nd byte of a long command, release, send 8'h00 x5 -> five sump_reset pulses, cmd_data=0, no stale payload.
